instr_fetch: RTL

- Instruction fetch stage directly downstream of the program counter `pc`.
- Takes the current PC value and issues in-order read requests to instruction memory over a valid/ready handshake.
- Buffers returned words with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles redirect flushes (pc_sel) by discarding stale in-flight responses, holds the PC under back-pressure, and flags misaligned fetch addresses.

---
 rtl/instr_fetch_pkg.sv | 11 +
 rtl/instr_fetch_fifo.sv | 44 ++++
 rtl/instr_fetch.sv | 70 +++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared widths, the NOP returned for faulted fetches,
// and the layout of one buffered fetch entry.
package instr_fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misaligned;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with occupancy count, flush and same-cycle push/pop at any level.
// dout reads as zero while empty.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd, wr;
    logic          do_pop;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign do_pop = pop && count != '0;
    assign dout   = count != '0 ? mem[rd] : '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= inc(wr);
            if (do_pop) rd <= inc(rd);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
    // When full, a push lands on the slot being popped this same cycle.
    always_ff @(posedge clk)
        if (push && !flush) mem[wr] <= din;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: issues in-order imem reads for pc, buffers returned words for decode,
// drops responses made stale by a redirect and faults misaligned fetch addresses.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic            pc_sel,
    output logic            pc_stall,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_misaligned,
    input  logic            if_ready
);
    fetch_entry_t     push_entry, head;
    logic [CNT_W-1:0] fifo_count, aq_count, drop_cnt;
    logic [XLEN-1:0]  aq_head;
    logic             halted, credit, misaligned, req_fire, rsp, rsp_push, mis_push;

    // The address queue occupancy doubles as the outstanding-request count.
    assign credit = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(aq_count) < (CNT_W + 1)'(FIFO_DEPTH);
    assign misaligned     = pc[1:0] != 2'b00;
    assign imem_req_valid = !reset && !pc_sel && !halted && credit && !misaligned;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pc_stall       = !reset && !pc_sel && !req_fire;
    // A response with nothing in flight (issued before a reset) is ignored.
    assign rsp      = imem_rsp_valid && aq_count != '0;
    assign rsp_push = rsp && drop_cnt == '0 && !pc_sel;
    assign mis_push = misaligned && !pc_sel && !halted && aq_count == '0 && credit;
    assign push_entry = mis_push ? fetch_entry_t'{pc: pc, instr: NOP_INSTR, misaligned: 1'b1}
                                 : fetch_entry_t'{pc: aq_head, instr: imem_rsp_data, misaligned: 1'b0};
    assign if_valid      = fifo_count != '0 && !pc_sel;
    assign if_instr      = head.instr;
    assign if_pc         = head.pc;
    assign if_misaligned = head.misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted   <= 1'b0;
            drop_cnt <= '0;
        end else if (pc_sel) begin
            halted   <= 1'b0;
            drop_cnt <= aq_count - CNT_W'(rsp);
        end else begin
            if (mis_push) halted <= 1'b1;
            if (rsp && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        end
    end

    fetch_fifo #(.W(XLEN), .DEPTH(FIFO_DEPTH), .CW(CNT_W)) u_addr_q (
        .clk(clk), .reset(reset), .flush(1'b0), .push(req_fire), .pop(rsp),
        .din(pc), .dout(aq_head), .count(aq_count)
    );

    fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH), .CW(CNT_W)) u_out_q (
        .clk(clk), .reset(reset), .flush(pc_sel), .push(rsp_push || mis_push),
        .pop(if_valid && if_ready), .din(push_entry), .dout(head), .count(fifo_count)
    );
endmodule
